grid_pixel_server: RTL and testbench
====================================

# grid_pixel_server

Responder for the VGA scan interface. The VGA controller presents a scan coordinate with a valid flag; this block answers with the pixel's on/off value from a double-buffered 10x20 Tetris board, drawing the well walls itself. Game logic writes only the back bank through a write port and commits changes. The commit takes effect at the next frame boundary (`draw_finish`), so the visible board never tears mid-frame.

## Interface
- `GRID_W`, 10: board columns (max 15).
- `GRID_H`, 20: board rows (max 31).
- `CELL_SHIFT`, 3: log2 of cell size in coordinate units.
- `X_ORG`, 8'd40: x coordinate of the left wall cell's first pixel.
- `Y_ORG`, 8'd0: y coordinate of the top board row's first pixel.

- `vga_clk` in 1: 25 MHz clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `x_coord` in 8: scan x from the VGA controller.
- `y_coord` in 8: scan y from the VGA controller.
- `display_data` in 1: scan is in the active area; acts as request valid.
- `draw_finish` in 1: one-cycle end-of-frame pulse.
- `coord_value` out 1: pixel value, 2 cycles after the request.
- `wr_en` in 1: write one back-bank cell.
- `wr_row` in 5: row index of the write.
- `wr_col` in 4: column index of the write.
- `wr_data` in 1: cell value to write.
- `clr` in 1: clear the whole back bank.
- `commit` in 1: request a bank swap at the next `draw_finish`.
- `busy` out 1: a COPY or CLEAR is in progress; writes are dropped while high.
- `frame_swapped` out 1: one-cycle pulse on the cycle after a swap.

## Operation
- **Storage:** two register banks, each GRID_H rows of GRID_W bits. `front_sel` selects which bank is front. The scan reads only the front bank; writes go only to the back bank.
- **Reset values:** both banks 0, `front_sel`=0, `pending`=0, state IDLE, `coord_value`=0, `busy`=0, `frame_swapped`=0.
- **Read mapping:**
  - dx = x_coord − X_ORG, dy = y_coord − Y_ORG, both 8-bit unsigned.
  - col = (dx>>CELL_SHIFT) − 1, row = dy>>CELL_SHIFT.
  - If x_coord < X_ORG or y_coord < Y_ORG, the pixel is outside and reads 0 (no wrap).
- **Pixel value** (meaningful only when `display_data`=1, else 0):
  - dx cell 0 or dx cell GRID_W+1, with row ≤ GRID_H: wall → 1.
  - row == GRID_H, with dx cell 0..GRID_W+1: floor → 1.
  - col in 0..GRID_W−1 and row in 0..GRID_H−1: front bank bit [row][col].
  - Anything else → 0.
- **Write port:** `wr_en` in IDLE writes back[wr_row][wr_col] = wr_data. Out-of-range row or column is ignored. A write during COPY or CLEAR is dropped.
- **Commit:** `commit` sets `pending`, whether or not `busy` is high.
- **Swap condition:** state IDLE, `pending`=1 and `draw_finish`=1 in the same cycle. On swap:
  - toggle `front_sel`, clear `pending`;
  - pulse `frame_swapped` next cycle;
  - enter COPY.
- **COPY:** copy new-front row r to new-back row r, one row per cycle, r = 0..GRID_H−1 (GRID_H cycles), then return to IDLE. The back bank then again mirrors the visible board.
- **CLEAR:** entered on `clr` in IDLE. Zero back row r, one per cycle, for GRID_H cycles, then IDLE.
- **Priority in IDLE** (same cycle): swap > clr > wr_en.
  - A losing `clr` is dropped.
  - A losing write is dropped.
- **draw_finish while not IDLE:** the swap is deferred; `pending` holds until a `draw_finish` arrives in IDLE.
- **`clr` outside IDLE:** ignored.
- **Reset mid-COPY/CLEAR:** all state returns to reset values immediately; the partial copy is discarded.

## Timing
- **Read pipeline:** request at cycle N. Stage 1 registers the decoded cell and valid at N+1; stage 2 registers `coord_value` at N+2. Fixed latency 2, one result per cycle, no stalls.
- **Read/swap timing:** stage 2 reads the `front_sel` value current at N+1. A swap does not corrupt pixels in flight, because the swap occurs only at `draw_finish`, outside the active area.
- **busy:** high on the cycle after the COPY/CLEAR entry edge. It stays high for exactly GRID_H cycles and is low in IDLE.
- **Write visibility:** a write at cycle N is visible in the back bank at N+1. It reaches the screen only after a commit and swap.
- **Row counter:** 5-bit; terminal count GRID_H−1; no wrap beyond it.

## Test plan
- **Reset and empty board:** hold `rst_n`=0 for 3 cycles, then scan x=48, y=0 with `display_data`=1 → `coord_value`=0 two cycles later. x=40 (wall) → 1. x=40, display_data=0 → 0.
- **Write, commit, swap:**
  - write (row 19, col 0, 1), `commit`, pulse `draw_finish` → `frame_swapped` pulses once.
  - `busy` is high for 20 cycles.
  - scan x=48, y=152 → 1.
  - before the swap, the same scan → 0.
- **Deferred swap:**
  - `clr`, then `commit` and `draw_finish` during CLEAR → no swap; `pending` is held.
  - next `draw_finish` after `busy` falls → swap.
- **Same-cycle collision:** in IDLE with `pending`=1, assert `draw_finish`, `clr` and `wr_en` (row 0, col 0, 1) together → swap occurs; the clear and the write are both dropped; back row 0 equals front after COPY.
- **Boundaries:** write to wr_row=20 or wr_col=10 → no change. Scan x=39 → 0. x=128 (right wall, dx cell 11) → 1. y=160 (floor) → 1. y=168 → 0.
- **Reset mid-COPY:** drop `rst_n` on COPY cycle 5 → next cycle `busy`=0, `front_sel`=0, and all scans of board cells return 0.

Source files
------------

// File: rtl/grid_pixel_server.sv
// Pixel server for the VGA scan: double-buffered Tetris board with drawn well walls/floor.
// Game logic writes the back bank; a commit swaps banks at the next frame boundary.
module grid_pixel_server #(
   parameter int         GRID_W     = 10,
   parameter int         GRID_H     = 20,
   parameter int         CELL_SHIFT = 3,
   parameter logic [7:0] X_ORG      = 8'd40,
   parameter logic [7:0] Y_ORG      = 8'd0
) (
   input  logic       vga_clk,
   input  logic       rst_n,
   input  logic [7:0] x_coord,
   input  logic [7:0] y_coord,
   input  logic       display_data,
   input  logic       draw_finish,
   output logic       coord_value,
   input  logic       wr_en,
   input  logic [4:0] wr_row,
   input  logic [3:0] wr_col,
   input  logic       wr_data,
   input  logic       clr,
   input  logic       commit,
   output logic       busy,
   output logic       frame_swapped
);

   typedef enum logic [1:0] {ST_IDLE, ST_COPY, ST_CLEAR} state_e;
   typedef enum logic [1:0] {PIX_ZERO, PIX_ONE, PIX_CELL} pix_e;

   localparam logic [7:0] CELLS_X  = 8'(GRID_W);
   localparam logic [7:0] WALL_R   = 8'(GRID_W + 1);
   localparam logic [7:0] FLOOR_Y  = 8'(GRID_H);
   localparam logic [4:0] ROW_LAST = 5'(GRID_H - 1);
   localparam logic [4:0] WR_ROWS  = 5'(GRID_H);
   localparam logic [3:0] WR_COLS  = 4'(GRID_W);

   state_e state_q, state_d;
   logic [4:0] row_cnt_q, row_cnt_d;

   logic [GRID_H-1:0][GRID_W-1:0] bank0_q, bank0_d, bank1_q, bank1_d;
   logic front_sel_q, front_sel_d;
   logic pending_q, pending_d;
   logic frame_swapped_q, frame_swapped_d;

   pix_e       pix_sel_q, pix_sel_d;
   logic [4:0] s1_row_q, s1_row_d;
   logic [3:0] s1_col_q, s1_col_d;
   logic       coord_value_q, coord_value_d;

   logic swap, clr_go, wr_go, copy_row, clear_row;
   logic [8:0] dx_full, dy_full;
   logic [7:0] dx_cell, dy_cell;

   // ---------------- FSM: state register ----------------
   // NOTE: every flop is written with <= so all registers update together on the edge.
   always_ff @(posedge vga_clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         row_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
      end
   end

   // ---------------- FSM: next state ----------------
   // NOTE: each combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      case (state_q)
         ST_IDLE: begin
            row_cnt_d = '0;
            if (swap)     state_d = ST_COPY;
            else if (clr) state_d = ST_CLEAR;
         end
         ST_COPY, ST_CLEAR: begin
            if (row_cnt_q == ROW_LAST) begin
               state_d   = ST_IDLE;
               row_cnt_d = '0;
            end else begin
               row_cnt_d = row_cnt_q + 5'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy      = (state_q != ST_IDLE);
      swap      = (state_q == ST_IDLE) && pending_q && draw_finish;
      clr_go    = (state_q == ST_IDLE) && !swap && clr;
      wr_go     = (state_q == ST_IDLE) && !swap && !clr && wr_en &&
                  (wr_row < WR_ROWS) && (wr_col < WR_COLS);
      copy_row  = (state_q == ST_COPY);
      clear_row = (state_q == ST_CLEAR);
   end

   // ---------------- Bank update ----------------
   // During COPY front_sel_q already holds the new front, so bank0 is back when front_sel_q=1.
   always_comb begin
      bank0_d         = bank0_q;
      bank1_d         = bank1_q;
      front_sel_d     = front_sel_q;
      pending_d       = pending_q;
      frame_swapped_d = swap;
      if (swap) begin
         front_sel_d = ~front_sel_q;
         pending_d   = 1'b0;
      end
      if (commit) pending_d = 1'b1;
      if (wr_go) begin
         if (front_sel_q) bank0_d[wr_row][wr_col] = wr_data;
         else             bank1_d[wr_row][wr_col] = wr_data;
      end
      if (copy_row) begin
         if (front_sel_q) bank0_d[row_cnt_q] = bank1_q[row_cnt_q];
         else             bank1_d[row_cnt_q] = bank0_q[row_cnt_q];
      end
      if (clear_row) begin
         if (front_sel_q) bank0_d[row_cnt_q] = '0;
         else             bank1_d[row_cnt_q] = '0;
      end
   end

   // ---------------- Read pipeline stage 1: decode ----------------
   always_comb begin
      dx_full   = {1'b0, x_coord} - {1'b0, X_ORG};
      dy_full   = {1'b0, y_coord} - {1'b0, Y_ORG};
      dx_cell   = dx_full[7:0] >> CELL_SHIFT;
      dy_cell   = dy_full[7:0] >> CELL_SHIFT;
      pix_sel_d = PIX_ZERO;
      s1_row_d  = '0;
      s1_col_d  = '0;
      // A borrow out of the subtraction means the scan is left of / above the well.
      if (display_data && !dx_full[8] && !dy_full[8]) begin
         if ((dx_cell == 8'd0 || dx_cell == WALL_R) && dy_cell <= FLOOR_Y) begin
            pix_sel_d = PIX_ONE;
         end else if (dy_cell == FLOOR_Y && dx_cell <= WALL_R) begin
            pix_sel_d = PIX_ONE;
         end else if (dx_cell <= CELLS_X && dy_cell < FLOOR_Y) begin
            pix_sel_d = PIX_CELL;
            s1_row_d  = 5'(dy_cell);
            s1_col_d  = 4'(dx_cell - 8'd1);
         end
      end
   end

   // ---------------- Read pipeline stage 2: front-bank lookup ----------------
   always_comb begin
      coord_value_d = 1'b0;
      case (pix_sel_q)
         PIX_ONE:  coord_value_d = 1'b1;
         PIX_CELL: coord_value_d = front_sel_q ? bank1_q[s1_row_q][s1_col_q]
                                               : bank0_q[s1_row_q][s1_col_q];
         default:  coord_value_d = 1'b0;
      endcase
   end

   // NOTE: the board banks are reset too, because the visible board must start empty.
   always_ff @(posedge vga_clk) begin
      if (!rst_n) begin
         bank0_q         <= '0;
         bank1_q         <= '0;
         front_sel_q     <= 1'b0;
         pending_q       <= 1'b0;
         frame_swapped_q <= 1'b0;
         pix_sel_q       <= PIX_ZERO;
         s1_row_q        <= '0;
         s1_col_q        <= '0;
         coord_value_q   <= 1'b0;
      end else begin
         bank0_q         <= bank0_d;
         bank1_q         <= bank1_d;
         front_sel_q     <= front_sel_d;
         pending_q       <= pending_d;
         frame_swapped_q <= frame_swapped_d;
         pix_sel_q       <= pix_sel_d;
         s1_row_q        <= s1_row_d;
         s1_col_q        <= s1_col_d;
         coord_value_q   <= coord_value_d;
      end
   end

   assign coord_value   = coord_value_q;
   assign frame_swapped = frame_swapped_q;

endmodule

// File: tb/tb_grid_pixel_server.sv
// Directed bench for grid_pixel_server: reset, write/commit/swap, deferred swap,
// same-cycle collision, boundaries and reset during COPY.
module tb_grid_pixel_server;

   logic       vga_clk;
   logic       rst_n;
   logic [7:0] x_coord, y_coord;
   logic       display_data, draw_finish;
   logic       coord_value;
   logic       wr_en;
   logic [4:0] wr_row;
   logic [3:0] wr_col;
   logic       wr_data, clr, commit;
   logic       busy, frame_swapped;

   int vectors;
   int miscompares;

   grid_pixel_server dut (
      .vga_clk      (vga_clk),
      .rst_n        (rst_n),
      .x_coord      (x_coord),
      .y_coord      (y_coord),
      .display_data (display_data),
      .draw_finish  (draw_finish),
      .coord_value  (coord_value),
      .wr_en        (wr_en),
      .wr_row       (wr_row),
      .wr_col       (wr_col),
      .wr_data      (wr_data),
      .clr          (clr),
      .commit       (commit),
      .busy         (busy),
      .frame_swapped(frame_swapped)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   // Request at one negedge; result sampled at the negedge after the second rising edge.
   task automatic scan(input logic [7:0] x, input logic [7:0] y, input logic dv, output logic v);
      x_coord      = x;
      y_coord      = y;
      display_data = dv;
      @(negedge vga_clk);
      display_data = 1'b0;
      @(negedge vga_clk);
      v = coord_value;
   endtask

   task automatic write_cell(input logic [4:0] r, input logic [3:0] c, input logic d);
      wr_en   = 1'b1;
      wr_row  = r;
      wr_col  = c;
      wr_data = d;
      @(negedge vga_clk);
      wr_en = 1'b0;
   endtask

   task automatic pulse_commit();
      commit = 1'b1;
      @(negedge vga_clk);
      commit = 1'b0;
   endtask

   // Samples from the current negedge until busy drops (bounded), counting busy and frame_swapped.
   task automatic wait_idle(output int bc, output int fc);
      bc = 0;
      fc = 0;
      for (int i = 0; i < 60; i++) begin
         if (frame_swapped) fc++;
         if (!busy) break;
         bc++;
         @(negedge vga_clk);
      end
   endtask

   task automatic do_swap(output int bc, output int fc);
      draw_finish = 1'b1;
      @(negedge vga_clk);
      draw_finish = 1'b0;
      wait_idle(bc, fc);
   endtask

   task automatic test_reset();
      logic v;
      rst_n = 1'b0;
      repeat (3) @(negedge vga_clk);
      vectors++;
      if (busy !== 1'b0 || frame_swapped !== 1'b0 || coord_value !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: busy=%b fs=%b cv=%b, want 0 0 0", busy, frame_swapped, coord_value);
      end
      rst_n = 1'b1;
      @(negedge vga_clk);
      scan(8'd48, 8'd0, 1'b1, v);
      vectors++;
      if (v !== 1'b0) begin miscompares++; $display("FAIL reset_empty_cell: got %b want 0", v); end
      scan(8'd40, 8'd0, 1'b1, v);
      vectors++;
      if (v !== 1'b1) begin miscompares++; $display("FAIL reset_left_wall: got %b want 1", v); end
      scan(8'd40, 8'd0, 1'b0, v);
      vectors++;
      if (v !== 1'b0) begin miscompares++; $display("FAIL wall_not_displayed: got %b want 0", v); end
   endtask

   task automatic test_write_commit_swap();
      logic v;
      int bc, fc;
      write_cell(5'd19, 4'd0, 1'b1);
      pulse_commit();
      scan(8'd48, 8'd152, 1'b1, v);
      vectors++;
      if (v !== 1'b0) begin miscompares++; $display("FAIL pre_swap_hidden: got %b want 0", v); end
      do_swap(bc, fc);
      vectors++;
      if (fc !== 1) begin miscompares++; $display("FAIL swap_pulse_count: got %0d want 1", fc); end
      vectors++;
      if (bc !== 20) begin miscompares++; $display("FAIL copy_busy_cycles: got %0d want 20", bc); end
      scan(8'd48, 8'd152, 1'b1, v);
      vectors++;
      if (v !== 1'b1) begin miscompares++; $display("FAIL post_swap_visible: got %b want 1", v); end
   endtask

   task automatic test_deferred_swap();
      logic v;
      int bc, fc;
      clr = 1'b1;
      @(negedge vga_clk);
      clr = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL clear_busy_start: got %b want 1", busy); end
      pulse_commit();
      draw_finish = 1'b1;
      @(negedge vga_clk);
      draw_finish = 1'b0;
      wait_idle(bc, fc);
      vectors++;
      if (fc !== 0) begin miscompares++; $display("FAIL no_swap_in_clear: got %0d pulses want 0", fc); end
      vectors++;
      if (bc !== 18 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_busy_tail: got %0d cycles busy=%b, want 18 and 0", bc, busy);
      end
      scan(8'd48, 8'd152, 1'b1, v);
      vectors++;
      if (v !== 1'b1) begin miscompares++; $display("FAIL front_kept_during_clear: got %b want 1", v); end
      do_swap(bc, fc);
      vectors++;
      if (fc !== 1 || bc !== 20) begin
         miscompares++;
         $display("FAIL deferred_swap: got pulses=%0d busy=%0d want 1 and 20", fc, bc);
      end
      scan(8'd48, 8'd152, 1'b1, v);
      vectors++;
      if (v !== 1'b0) begin miscompares++; $display("FAIL cleared_bank_shown: got %b want 0", v); end
   endtask

   task automatic test_collision();
      logic v;
      int bc, fc;
      write_cell(5'd5, 4'd3, 1'b1);
      pulse_commit();
      draw_finish = 1'b1;
      clr         = 1'b1;
      wr_en       = 1'b1;
      wr_row      = 5'd0;
      wr_col      = 4'd0;
      wr_data     = 1'b1;
      @(negedge vga_clk);
      draw_finish = 1'b0;
      clr         = 1'b0;
      wr_en       = 1'b0;
      wait_idle(bc, fc);
      vectors++;
      if (fc !== 1 || bc !== 20) begin
         miscompares++;
         $display("FAIL collision_swap: got pulses=%0d busy=%0d want 1 and 20", fc, bc);
      end
      scan(8'd72, 8'd40, 1'b1, v);
      vectors++;
      if (v !== 1'b1) begin miscompares++; $display("FAIL collision_front_cell: got %b want 1", v); end
      scan(8'd48, 8'd0, 1'b1, v);
      vectors++;
      if (v !== 1'b0) begin miscompares++; $display("FAIL collision_write_dropped: got %b want 0", v); end
      pulse_commit();
      do_swap(bc, fc);
      scan(8'd72, 8'd40, 1'b1, v);
      vectors++;
      if (v !== 1'b1) begin miscompares++; $display("FAIL copy_mirrored_back: got %b want 1", v); end
      scan(8'd48, 8'd0, 1'b1, v);
      vectors++;
      if (v !== 1'b0) begin miscompares++; $display("FAIL back_row0_clean: got %b want 0", v); end
   endtask

   task automatic test_boundaries();
      logic [7:0] xs [12] = '{8'd120, 8'd48, 8'd48, 8'd72, 8'd39, 8'd40,
                              8'd128, 8'd136, 8'd80, 8'd40, 8'd128, 8'd48};
      logic [7:0] ys [12] = '{8'd0, 8'd8, 8'd0, 8'd40, 8'd0, 8'd0,
                              8'd0, 8'd0, 8'd160, 8'd168, 8'd160, 8'd152};
      logic       ex [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                              1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic v;
      int bc, fc;
      write_cell(5'd20, 4'd0, 1'b1);
      write_cell(5'd0, 4'd10, 1'b1);
      write_cell(5'd31, 4'd15, 1'b1);
      pulse_commit();
      do_swap(bc, fc);
      for (int i = 0; i < 12; i++) begin
         scan(xs[i], ys[i], 1'b1, v);
         vectors++;
         if (v !== ex[i]) begin
            miscompares++;
            $display("FAIL boundary_scan x=%0d y=%0d: got %b want %b", xs[i], ys[i], v, ex[i]);
         end
      end
   endtask

   task automatic test_reset_mid_copy();
      logic v;
      int bc, fc;
      pulse_commit();
      do_swap(bc, fc);
      pulse_commit();
      draw_finish = 1'b1;
      @(negedge vga_clk);
      draw_finish = 1'b0;
      repeat (4) @(negedge vga_clk);
      rst_n = 1'b0;
      @(negedge vga_clk);
      vectors++;
      if (busy !== 1'b0 || frame_swapped !== 1'b0 || dut.front_sel_q !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_copy_reset: busy=%b fs=%b front_sel=%b want 0 0 0",
                  busy, frame_swapped, dut.front_sel_q);
      end
      rst_n = 1'b1;
      @(negedge vga_clk);
      scan(8'd72, 8'd40, 1'b1, v);
      vectors++;
      if (v !== 1'b0) begin miscompares++; $display("FAIL mid_copy_board_cleared: got %b want 0", v); end
      scan(8'd40, 8'd40, 1'b1, v);
      vectors++;
      if (v !== 1'b1) begin miscompares++; $display("FAIL mid_copy_wall: got %b want 1", v); end
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      x_coord      = '0;
      y_coord      = '0;
      display_data = 1'b0;
      draw_finish  = 1'b0;
      wr_en        = 1'b0;
      wr_row       = '0;
      wr_col       = '0;
      wr_data      = 1'b0;
      clr          = 1'b0;
      commit       = 1'b0;
      rst_n        = 1'b0;
      @(negedge vga_clk);
      test_reset();
      test_write_commit_swap();
      test_deferred_swap();
      test_collision();
      test_boundaries();
      test_reset_mid_copy();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
